// File: rtl/psum_drain_pkg.sv
// Shared types and sizing for the PE partial-sum drain path.
// The PSUM_DRAIN_SKID_EN build option is resolved in psum_drain.sv; nothing here depends on it.
package psum_drain_pkg;

    localparam int PEROW   = 8;
    localparam int PSUMDWD = 32;
    localparam int PBDWD   = 32;
    localparam int PBAWD   = 10;
    localparam int SUMWD   = PEROW * PSUMDWD;
    localparam int BEATWD  = $clog2(PEROW);
    localparam int LANEWD  = $clog2(PSUMDWD);

    typedef enum logic {
        D16 = 1'b0,
        D32 = 1'b1
    } psum_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [SUMWD-1:0] sum;
        psum_mode_e       mode;
        logic [PBAWD-1:0] base;
    } pd_vec_t;

    // D16 packs two rows per word, so it needs half the beats of D32.
    function automatic logic [BEATWD-1:0] last_beat_idx(input psum_mode_e mode);
        return (mode == D32) ? BEATWD'(PEROW - 1) : BEATWD'(PEROW / 2 - 1);
    endfunction

endpackage

// File: rtl/psum_pack.sv
// Combinational beat formatter: picks the lane(s) for the current beat and forms the
// buffer address and write word.
module psum_pack
    import psum_drain_pkg::*;
(
    input  logic [SUMWD-1:0]  sum,
    input  logic              mode,
    input  logic [PBAWD-1:0]  base,
    input  logic [BEATWD-1:0] beat,
    output logic [PBAWD-1:0]  waddr,
    output logic [PBDWD-1:0]  wdata
);

    logic [BEATWD-1:0] lane_lo;
    logic [BEATWD-1:0] lane_hi;

    assign lane_lo = {beat[BEATWD-2:0], 1'b0};
    assign lane_hi = {beat[BEATWD-2:0], 1'b1};

    always_comb begin
        // NOTE: default first so every path assigns wdata and no latch is inferred.
        wdata = '0;
        if (psum_mode_e'(mode) == D32) begin
            wdata = sum[{beat, {LANEWD{1'b0}}} +: PBDWD];
        end else begin
            wdata = {sum[{lane_hi, {LANEWD{1'b0}}} +: 16],
                     sum[{lane_lo, {LANEWD{1'b0}}} +: 16]};
        end
    end

    // Wraps modulo 2^PBAWD by construction.
    assign waddr = base + PBAWD'(beat);

endmodule

// File: rtl/psum_drain.sv
// Captures one PE psum vector per PS transfer and serializes it onto the psum buffer write port.
// Build option: PSUM_DRAIN_SKID_EN adds a one-vector skid register for gap-free back-to-back vectors.
module psum_drain
    import psum_drain_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               PS_rdy,
    output logic               PS_ack,
    input  logic [SUMWD-1:0]   i_sum,
    input  logic               i_mode,
    input  logic [PBAWD-1:0]   i_base,
    output logic               PB_rdy,
    input  logic               PB_ack,
    output logic [PBAWD-1:0]   o_waddr,
    output logic [PBDWD-1:0]   o_wdata,
    output logic               o_busy
);

    drain_state_e      state, state_nxt;
    logic [BEATWD-1:0] beat, beat_nxt;
    pd_vec_t           main_q, main_d, in_vec, skid_q;
    logic              main_en;
    logic              skid_full;
    logic              ps_xfer;
    logic              pb_beat;
    logic              last_beat;

    assign in_vec    = '{sum: i_sum, mode: psum_mode_e'(i_mode), base: i_base};
    assign ps_xfer   = PS_rdy && PS_ack;
    assign pb_beat   = (state == DRAIN) && PB_ack;
    assign last_beat = pb_beat && (beat == last_beat_idx(main_q.mode));

`ifdef PSUM_DRAIN_SKID_EN
    logic skid_load;
    logic skid_clr;

    // A transfer landing on the last beat goes straight to main instead.
    assign skid_load = ps_xfer && (state == DRAIN) && !last_beat;
    assign skid_clr  = last_beat && skid_full;
    assign PS_ack    = !skid_full;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (skid_load) begin
            skid_full <= 1'b1;
            skid_q    <= in_vec;
        end else if (skid_clr) begin
            skid_full <= 1'b0;
        end
    end
`else
    assign skid_full = 1'b0;
    assign skid_q    = '0;
    assign PS_ack    = (state == IDLE);
`endif

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        main_en   = 1'b0;
        main_d    = in_vec;
        case (state)
            IDLE: begin
                if (ps_xfer) begin
                    main_en   = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    beat_nxt = '0;
                    if (skid_full) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end else if (ps_xfer) begin
                        main_en = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (pb_beat) begin
                    beat_nxt = beat + BEATWD'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            state  <= IDLE;
            beat   <= '0;
            main_q <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (main_en) begin
                main_q <= main_d;
            end
        end
    end

    psum_pack u_pack (
        .sum   (main_q.sum),
        .mode  (main_q.mode),
        .base  (main_q.base),
        .beat  (beat),
        .waddr (o_waddr),
        .wdata (o_wdata)
    );

    assign PB_rdy = (state == DRAIN);
    assign o_busy = (state == DRAIN) || skid_full;

endmodule
